sigmoid_mac_stage: RTL

//  Downstream evaluation stage of the piecewise-linear sigmoid approximator.

---
 rtl/sigmoid_mac_stage.sv | 97 +++++++++
 1 files changed

// File: rtl/sigmoid_mac_stage.sv
// Evaluation stage of the piecewise-linear sigmoid: y = clamp(round(grad*x) + offset, 0, Y_MAX).
// Two-register valid/ready pipeline. There is no skid buffer, so in_ready depends combinationally on out_ready.
module sigmoid_mac_stage #(
    parameter int              DW    = 16,
    parameter int              FRAC  = 8,
    parameter logic [DW-1:0]   Y_MAX = 16'h0100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_grad,
    input  logic [DW-1:0] in_offset,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_y,
    output logic          out_sat
);

    localparam int PW = 2 * DW;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] ROUND_HALF = SW'(1) << (FRAC - 1);
    localparam logic signed [SW-1:0] Y_MAX_EXT  = {{(SW - DW){1'b0}}, Y_MAX};

    logic                 adv1;
    logic                 adv2;
    logic                 v1;
    logic signed [PW-1:0] p1;
    logic        [DW-1:0] off1;

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] t;
    logic signed [SW-1:0] s;
    logic                 sat_lo;
    logic                 sat_hi;
    logic        [DW-1:0] y_next;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    // Grad is an unsigned magnitude, so it is zero-extended and x is sign-extended.
    // The low PW bits of the product of the extended operands are then exact.
    always_comb begin
        x_ext = {{DW{in_x[DW-1]}}, in_x};
        g_ext = {{DW{1'b0}}, in_grad};
        prod  = x_ext * g_ext;
    end

    // NOTE: give every always_comb output a value on every path, here by plain unconditional assignment, so no latch is inferred.
    always_comb begin
        rnd    = {p1[PW-1], p1} + ROUND_HALF;
        t      = rnd >>> FRAC;
        s      = t + {{(SW - DW){off1[DW-1]}}, off1};
        sat_lo = s[SW-1];
        sat_hi = !sat_lo && (s > Y_MAX_EXT);
        y_next = s[DW-1:0];
        if (sat_lo) begin
            y_next = '0;
        end else if (sat_hi) begin
            y_next = Y_MAX;
        end
    end

    // NOTE: the datapath registers are reset as well as the valid bits, so the output reads 0 during reset and right after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            p1   <= '0;
            off1 <= '0;
        end else if (adv1) begin
            // NOTE: use non-blocking assignments for state so that every register samples its value from before the edge.
            v1 <= in_valid;
            if (in_valid) begin
                p1   <= prod;
                off1 <= in_offset;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sat   <= 1'b0;
        end else if (adv2) begin
            out_valid <= v1;
            out_y     <= y_next;
            out_sat   <= sat_lo || sat_hi;
        end
    end

endmodule
